// File: rtl/kl_branch_pkg.sv
// Shared branch types for the split-branch scheme (branch_decode, branch unit,
// delayed_branch_resolver).
//   cond_t      : 3-bit delayed-branch condition code
//   dly_entry_t : one delayed-pipe slot {ind, dest, cond, vld}
//   cond_met()  : evaluates a condition against the N/V/Z flags
package kl_branch_pkg;

    localparam int unsigned DESTW   = 8;
    localparam int unsigned COND_W  = 3;

    typedef enum logic [COND_W-1:0] {
        COND_NV = 3'd0,
        COND_AL = 3'd1,
        COND_EQ = 3'd2,
        COND_NE = 3'd3,
        COND_LT = 3'd4,
        COND_LE = 3'd5,
        COND_GT = 3'd6,
        COND_GE = 3'd7
    } cond_t;

    typedef struct packed {
        logic             ind;   // target comes from the target-branch register
        logic [DESTW-1:0] dest;
        cond_t            cond;
        logic             vld;
    } dly_entry_t;

    localparam int unsigned ENTRY_W = $bits(dly_entry_t);

    // Condition evaluation against the flags of the pair completing stage 3
    function automatic logic cond_met(cond_t cond, logic n, logic v, logic z);
        logic lt;
        logic met;
        lt  = n ^ v;
        met = 1'b0;
        case (cond)
            COND_NV: met = 1'b0;
            COND_AL: met = 1'b1;
            COND_EQ: met = z;
            COND_NE: met = ~z;
            COND_LT: met = lt;
            COND_LE: met = z | lt;
            COND_GT: met = ~z & ~lt;
            COND_GE: met = ~lt;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/dbr_cond_eval.sv
// Combinational two-slot evaluator for the stage-3 delayed entries.
// Slot 0 is the older instruction, so it has priority over slot 1.
//   slot0_i, slot1_i : packed dly_entry_t of the stage-3 slots
//   n_i, v_i, z_i    : flags of the pair completing stage 3
//   tbr_i            : target-branch register for indirect entries
//   hit0_c_o         : slot 0 valid and condition met
//   hit1_c_o         : slot 1 valid, condition met, slot 0 not taken
//   target_c_o       : destination of the winning slot
module dbr_cond_eval
    import kl_branch_pkg::*;
(
    input  logic [ENTRY_W-1:0] slot0_i,
    input  logic [ENTRY_W-1:0] slot1_i,
    input  logic               n_i,
    input  logic               v_i,
    input  logic               z_i,
    input  logic [DESTW-1:0]   tbr_i,
    output logic               hit0_c_o,
    output logic               hit1_c_o,
    output logic [DESTW-1:0]   target_c_o
);

    dly_entry_t e0;
    dly_entry_t e1;

    assign e0 = dly_entry_t'(slot0_i);
    assign e1 = dly_entry_t'(slot1_i);

    // Priority hit selection and target mux
    always_comb begin
        hit0_c_o   = e0.vld & cond_met(e0.cond, n_i, v_i, z_i);
        hit1_c_o   = e1.vld & cond_met(e1.cond, n_i, v_i, z_i) & ~hit0_c_o;
        target_c_o = '0;
        if (hit0_c_o) begin
            target_c_o = e0.ind ? tbr_i : e0.dest;
        end else if (hit1_c_o) begin
            target_c_o = e1.ind ? tbr_i : e1.dest;
        end
    end

endmodule

// File: rtl/delayed_branch_resolver.sv
// Consumer end of the split-branch scheme. Carries the delayed halves of
// branches (dest + cond, per slot p0/p1) two pipeline advances to stage 3,
// evaluates them against N/V/Z and issues a one-cycle PC redirect + flush.
// Optional build macro: DELAYED_BRANCH_STATS_EN adds taken_cnt_out.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   advance                       pipeline advance; low holds all state
//   pX_dly_b_in/cond_in/vld_in    slot X delayed entry ([15]=indirect)
//   N, V, Z                       flags of the pair completing stage 3
//   tbr_in                        target-branch register
//   redirect_out, flush_out       one-cycle pulse after a taken resolve
//   redirect_pc_out, odd_start_out  even-aligned fetch PC and dest[0]
//   busy_out                      any stage-2/stage-3 entry valid
//   taken_cnt_out (optional)      wrapping count of delayed hits
module delayed_branch_resolver
    import kl_branch_pkg::*;
#(
    parameter int unsigned PCW = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           advance,
    input  logic [15:0]    p0_dly_b_in,
    input  logic [2:0]     p0_dly_cond_in,
    input  logic           p0_dly_vld_in,
    input  logic [15:0]    p1_dly_b_in,
    input  logic [2:0]     p1_dly_cond_in,
    input  logic           p1_dly_vld_in,
    input  logic           N,
    input  logic           V,
    input  logic           Z,
    input  logic [7:0]     tbr_in,
    output logic           redirect_out,
    output logic [PCW-1:0] redirect_pc_out,
    output logic           odd_start_out,
    output logic           flush_out,
    output logic           busy_out
`ifdef DELAYED_BRANCH_STATS_EN
    ,
    output logic [15:0]    taken_cnt_out
`endif
);

    localparam int unsigned SLOTS = 2;
    localparam int unsigned CNT_W = 16;

    dly_entry_t       in_ent [SLOTS];
    dly_entry_t       s2_q   [SLOTS];
    dly_entry_t       s2_d   [SLOTS];
    dly_entry_t       s3_q   [SLOTS];
    dly_entry_t       s3_d   [SLOTS];

    logic             redirect_q, redirect_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             odd_q, odd_d;
    logic             busy_q, busy_d;

    logic             hit0, hit1, hit;
    logic [DESTW-1:0] target;

    // Bits [14:8] of the delayed-B word carry nothing for the resolver
    logic             unused_b_bits;
    assign unused_b_bits = ^{p0_dly_b_in[14:8], p1_dly_b_in[14:8]};

    // Unpack incoming slots into entries
    always_comb begin
        in_ent[0] = '{ind: p0_dly_b_in[15], dest: p0_dly_b_in[DESTW-1:0],
                      cond: cond_t'(p0_dly_cond_in), vld: p0_dly_vld_in};
        in_ent[1] = '{ind: p1_dly_b_in[15], dest: p1_dly_b_in[DESTW-1:0],
                      cond: cond_t'(p1_dly_cond_in), vld: p1_dly_vld_in};
    end

    dbr_cond_eval u_eval (
        .slot0_i    (s3_q[0]),
        .slot1_i    (s3_q[1]),
        .n_i        (N),
        .v_i        (V),
        .z_i        (Z),
        .tbr_i      (tbr_in),
        .hit0_c_o   (hit0),
        .hit1_c_o   (hit1),
        .target_c_o (target)
    );

    // Resolution only happens on an advance edge
    assign hit = advance & (hit0 | hit1);

    // Pipe advance, wrong-path squash and output next-state
    always_comb begin
        s2_d       = s2_q;
        s3_d       = s3_q;
        redirect_d = 1'b0;
        pc_d       = pc_q;
        odd_d      = odd_q;
        if (advance) begin
            s3_d = s2_q;
            s2_d = in_ent;
            if (hit) begin
                // Everything younger than the taken entry is wrong-path
                for (int i = 0; i < SLOTS; i++) begin
                    s2_d[i].vld = 1'b0;
                    s3_d[i].vld = 1'b0;
                end
                redirect_d = 1'b1;
                pc_d       = PCW'({target[DESTW-1:1], 1'b0});
                odd_d      = target[0];
            end
        end
        busy_d = s2_d[0].vld | s2_d[1].vld | s3_d[0].vld | s3_d[1].vld;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_q       <= '{default: '0};
            s3_q       <= '{default: '0};
            redirect_q <= 1'b0;
            pc_q       <= '0;
            odd_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            redirect_q <= redirect_d;
            pc_q       <= pc_d;
            odd_q      <= odd_d;
            busy_q     <= busy_d;
        end
    end

    assign redirect_out    = redirect_q;
    assign flush_out       = redirect_q;
    assign redirect_pc_out = pc_q;
    assign odd_start_out   = odd_q;
    assign busy_out        = busy_q;

`ifdef DELAYED_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    // Taken-delayed-branch counter, wraps naturally
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (hit) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign taken_cnt_out = taken_cnt_q;
`endif

endmodule

// File: tb/tb_delayed_branch_resolver.sv
// Self-checking bench for delayed_branch_resolver: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_delayed_branch_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        advance;
    logic [15:0] p0_dly_b_in, p1_dly_b_in;
    logic [2:0]  p0_dly_cond_in, p1_dly_cond_in;
    logic        p0_dly_vld_in, p1_dly_vld_in;
    logic        N, V, Z;
    logic [7:0]  tbr_in;
    logic        redirect_out;
    logic [8:0]  redirect_pc_out;
    logic        odd_start_out;
    logic        flush_out;
    logic        busy_out;
`ifdef DELAYED_BRANCH_STATS_EN
    logic [15:0] taken_cnt_out;
`endif

    delayed_branch_resolver #(.PCW(9)) dut (
        .clk             (clk),
        .rst             (rst),
        .advance         (advance),
        .p0_dly_b_in     (p0_dly_b_in),
        .p0_dly_cond_in  (p0_dly_cond_in),
        .p0_dly_vld_in   (p0_dly_vld_in),
        .p1_dly_b_in     (p1_dly_b_in),
        .p1_dly_cond_in  (p1_dly_cond_in),
        .p1_dly_vld_in   (p1_dly_vld_in),
        .N               (N),
        .V               (V),
        .Z               (Z),
        .tbr_in          (tbr_in),
        .redirect_out    (redirect_out),
        .redirect_pc_out (redirect_pc_out),
        .odd_start_out   (odd_start_out),
        .flush_out       (flush_out),
        .busy_out        (busy_out)
`ifdef DELAYED_BRANCH_STATS_EN
        ,
        .taken_cnt_out   (taken_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // Reference model: each queue holds the two in-flight pairs, oldest first
    typedef struct packed {
        bit       ind;
        bit [7:0] dest;
        bit [2:0] cond;
        bit       vld;
    } ent_t;

    ent_t      q0[$];
    ent_t      q1[$];
    bit        m_red;
    bit [8:0]  m_pc;
    bit        m_odd;
    bit        m_busy;
    bit [15:0] m_cnt;

    function automatic bit met(bit [2:0] c, bit n, bit v, bit z);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return n != v;
            3'd5: return z || (n != v);
            3'd6: return !z && (n == v);
            default: return n == v;
        endcase
    endfunction

    function automatic ent_t mk(logic [15:0] b, logic [2:0] c, logic vl);
        ent_t e;
        e.ind  = b[15];
        e.dest = b[7:0];
        e.cond = c;
        e.vld  = vl;
        return e;
    endfunction

    task automatic model_reset();
        q0 = {}; q1 = {};
        q0.push_back('0); q0.push_back('0);
        q1.push_back('0); q1.push_back('0);
        m_red = 0; m_pc = '0; m_odd = 0; m_cnt = '0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven
    task automatic model_edge();
        ent_t o0, o1, y;
        bit h0, h1;
        bit [7:0] tgt;
        m_red = 0;
        if (rst) begin
            model_reset();
        end else if (advance) begin
            o0 = q0.pop_front();
            o1 = q1.pop_front();
            h0 = o0.vld && met(o0.cond, N, V, Z);
            h1 = !h0 && o1.vld && met(o1.cond, N, V, Z);
            if (h0 || h1) begin
                if (h0) tgt = o0.ind ? tbr_in : o0.dest;
                else    tgt = o1.ind ? tbr_in : o1.dest;
                m_red = 1;
                m_pc  = {1'b0, tgt[7:1], 1'b0};
                m_odd = tgt[0];
                m_cnt = m_cnt + 16'd1;
                y = q0[0]; y.vld = 0; q0[0] = y;
                y = q1[0]; y.vld = 0; q1[0] = y;
                q0.push_back('0);
                q1.push_back('0);
            end else begin
                q0.push_back(mk(p0_dly_b_in, p0_dly_cond_in, p0_dly_vld_in));
                q1.push_back(mk(p1_dly_b_in, p1_dly_cond_in, p1_dly_vld_in));
            end
        end
        m_busy = q0[0].vld || q0[1].vld || q1[0].vld || q1[1].vld;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("redirect", 16'(redirect_out), 16'(m_red));
        chk("flush", 16'(flush_out), 16'(m_red));
        chk("pc", 16'(redirect_pc_out), 16'(m_pc));
        chk("odd", 16'(odd_start_out), 16'(m_odd));
        chk("busy", 16'(busy_out), 16'(m_busy));
`ifdef DELAYED_BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt_out, m_cnt);
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr_in();
        p0_dly_b_in = '0; p0_dly_cond_in = '0; p0_dly_vld_in = 0;
        p1_dly_b_in = '0; p1_dly_cond_in = '0; p1_dly_vld_in = 0;
    endtask

    initial begin
        model_reset();
        rst = 1; advance = 1; N = 0; V = 0; Z = 0; tbr_in = '0;
        clr_in();
        tick(); tick();
        chk("reset_busy", 16'(busy_out), 16'h0);
        chk("reset_redirect", 16'(redirect_out), 16'h0);
        rst = 0;

        // 1: p0 dest 0x13 EQ, Z=1 at resolve
        p0_dly_b_in = 16'h0013; p0_dly_cond_in = 3'd2; p0_dly_vld_in = 1;
        tick(); clr_in(); tick();
        Z = 1; tick();
        chk("t1_redirect", 16'(redirect_out), 16'h1);
        chk("t1_pc", 16'(redirect_pc_out), 16'h012);
        chk("t1_odd", 16'(odd_start_out), 16'h1);
        chk("t1_flush", 16'(flush_out), 16'h1);
`ifdef DELAYED_BRANCH_STATS_EN
        chk("t1_cnt", taken_cnt_out, 16'd1);
`endif
        Z = 0; tick();
        chk("t1_pulse_end", 16'(redirect_out), 16'h0);

        // 2: p0 EQ not met, p1 GE met -> p1 wins; then both met -> p0 wins
        p0_dly_b_in = 16'h0055; p0_dly_cond_in = 3'd2; p0_dly_vld_in = 1;
        p1_dly_b_in = 16'h0020; p1_dly_cond_in = 3'd7; p1_dly_vld_in = 1;
        tick(); clr_in(); tick();
        N = 1; V = 1; Z = 0; tick();
        chk("t2_pc_p1", 16'(redirect_pc_out), 16'h020);
        chk("t2_odd_p1", 16'(odd_start_out), 16'h0);
        p0_dly_b_in = 16'h0055; p0_dly_cond_in = 3'd2; p0_dly_vld_in = 1;
        p1_dly_b_in = 16'h0020; p1_dly_cond_in = 3'd7; p1_dly_vld_in = 1;
        tick(); clr_in(); tick();
        Z = 1; tick();
        chk("t2_pc_p0", 16'(redirect_pc_out), 16'h054);
        chk("t2_odd_p0", 16'(odd_start_out), 16'h1);

        // 3: NV on both slots never fires
        p0_dly_b_in = 16'h0077; p0_dly_cond_in = 3'd0; p0_dly_vld_in = 1;
        p1_dly_b_in = 16'h0066; p1_dly_cond_in = 3'd0; p1_dly_vld_in = 1;
        tick(); clr_in();
        for (int i = 0; i < 4; i++) begin
            N = i[0]; V = i[1]; Z = ~i[0];
            tick();
            chk("t3_no_redirect", 16'(redirect_out), 16'h0);
        end
        chk("t3_busy_drop", 16'(busy_out), 16'h0);

        // 4: indirect AL via tbr; the entry behind it is squashed
        p0_dly_b_in = 16'h8000; p0_dly_cond_in = 3'd1; p0_dly_vld_in = 1;
        tick();
        p0_dly_b_in = 16'h0008; p0_dly_cond_in = 3'd1; p0_dly_vld_in = 1;
        tick();
        tbr_in = 8'h41; tick();
        chk("t4_pc", 16'(redirect_pc_out), 16'h040);
        chk("t4_odd", 16'(odd_start_out), 16'h1);
        clr_in();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_squashed", 16'(redirect_out), 16'h0);
        end

        // 5: stall with AL in stage 3
        p1_dly_b_in = 16'h0031; p1_dly_cond_in = 3'd1; p1_dly_vld_in = 1;
        tick(); clr_in(); tick();
        advance = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall", 16'(redirect_out), 16'h0);
        end
        advance = 1; tick();
        chk("t5_pulse", 16'(redirect_out), 16'h1);
        chk("t5_pc", 16'(redirect_pc_out), 16'h030);
        tick();
        chk("t5_one_pulse", 16'(redirect_out), 16'h0);

        // 6: reset mid-flight drops pending work
        p0_dly_b_in = 16'h0044; p0_dly_cond_in = 3'd1; p0_dly_vld_in = 1;
        tick(); tick(); clr_in();
        rst = 1; tick(); rst = 0;
        chk("t6_busy", 16'(busy_out), 16'h0);
        tick();
        chk("t6_no_pulse", 16'(redirect_out), 16'h0);

        // Random traffic including stalls, pulses under stall and resets
        for (int i = 0; i < 500; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            advance        = ($urandom_range(0, 3) != 0);
            p0_dly_b_in    = 16'($urandom);
            p0_dly_cond_in = 3'($urandom);
            p0_dly_vld_in  = 1'($urandom);
            p1_dly_b_in    = 16'($urandom);
            p1_dly_cond_in = 3'($urandom);
            p1_dly_vld_in  = 1'($urandom);
            N = 1'($urandom); V = 1'($urandom); Z = 1'($urandom);
            tbr_in = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
